// File: rtl/datapath_param.sv
// BPF-style CPU datapath: A/X accumulators, PC with conditional branch, handshaked ALU,
// scratch regfile and LUT-RAM immediate / jump-offset tables, sequenced by axis_cpu.
module datapath_param #(
    parameter int DATA_WIDTH         = 32,
    parameter int CODE_ADDR_WIDTH    = 10,
    parameter int JMP_OFF_WIDTH      = 8,
    parameter int TABLE_ADDR_WIDTH   = 4,
    parameter int SCRATCH_ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    A_sel,
    input  logic                          A_en,
    input  logic [1:0]                    X_sel,
    input  logic                          X_en,
    input  logic [1:0]                    PC_sel,
    input  logic                          PC_en,
    input  logic [1:0]                    cond_sel,
    input  logic [CODE_ADDR_WIDTH-1:0]    jmp_correction,
    input  logic                          B_sel,
    input  logic [3:0]                    ALU_sel,
    input  logic                          ALU_en,
    input  logic                          ALU_ack,
    output logic                          ALU_vld,
    output logic [DATA_WIDTH-1:0]         ALU_out,
    output logic                          eq,
    output logic                          gt,
    output logic                          ge,
    output logic                          set,
    output logic                          branch_stall,
    input  logic [TABLE_ADDR_WIDTH-1:0]   utility_addr,
    input  logic                          imm_sel_en,
    input  logic                          jmp_off_sel_en,
    input  logic                          imm_wr_en,
    input  logic [TABLE_ADDR_WIDTH-1:0]   imm_wr_addr,
    input  logic [DATA_WIDTH-1:0]         imm_wr_data,
    input  logic                          jmp_off_wr_en,
    input  logic [TABLE_ADDR_WIDTH-1:0]   jmp_off_wr_addr,
    input  logic [JMP_OFF_WIDTH-1:0]      jmp_off_wr_data,
    input  logic [SCRATCH_ADDR_WIDTH-1:0] regfile_addr,
    input  logic                          regfile_sel,
    input  logic                          regfile_wr_en,
    output logic [CODE_ADDR_WIDTH-1:0]    PC_out,
    output logic [DATA_WIDTH-1:0]         A_out,
    output logic [DATA_WIDTH-1:0]         X_out
);

    localparam int DW  = DATA_WIDTH;
    localparam int CAW = CODE_ADDR_WIDTH;
    localparam int JOW = JMP_OFF_WIDTH;
    localparam int TAW = TABLE_ADDR_WIDTH;
    localparam int SAW = SCRATCH_ADDR_WIDTH;
    localparam logic [DW-1:0]  L_DW     = DW'(DW);
    localparam logic [CAW-1:0] L_PC_ONE = CAW'(1);

    localparam logic [1:0] A_IMM = 2'd0, A_MEM = 2'd1, A_ALU = 2'd2, A_X = 2'd3;
    localparam logic [1:0] X_IMM = 2'd0, X_MEM = 2'd1, X_A = 2'd2;
    localparam logic [1:0] PC_INC = 2'd0, PC_JMP = 2'd1, PC_BR = 2'd2;

    typedef enum logic {S_IDLE, S_VALID} alu_state_t;

    logic [DW-1:0]  r_imm_mem [0:(1<<TAW)-1];
    logic [JOW-1:0] r_jmp_mem [0:(1<<TAW)-1];
    logic [DW-1:0]  r_scr_mem [0:(1<<SAW)-1];

    logic [DW-1:0]  r_a, r_x, r_alu_out;
    logic [CAW-1:0] r_pc;
    logic [TAW-1:0] r_imm_sel, r_jmp_sel;
    logic           r_eq, r_gt, r_ge, r_set;
    alu_state_t     r_alu_state, w_alu_state_nxt;

    logic [DW-1:0]  w_imm, w_mem, w_alu_b, w_shamt, w_alu_res;
    logic [JOW-1:0] w_jmp_off;
    logic [CAW-1:0] w_jmp_ext, w_pc_inc, w_pc_jmp, w_pc_nxt;
    logic           w_alu_cap, w_flag, w_stall;

    // Tables and scratch are plain LUT-RAM: no reset, write on edge, comb read.
    always_ff @(posedge clk) begin
        if (imm_wr_en)     r_imm_mem[imm_wr_addr]     <= imm_wr_data;
        if (jmp_off_wr_en) r_jmp_mem[jmp_off_wr_addr] <= jmp_off_wr_data;
        if (regfile_wr_en) r_scr_mem[regfile_addr]    <= regfile_sel ? r_x : r_a;
    end

    assign w_imm     = r_imm_mem[r_imm_sel];
    assign w_jmp_off = r_jmp_mem[r_jmp_sel];
    assign w_mem     = r_scr_mem[regfile_addr];

    generate
        if (JOW >= CAW) begin : g_off_trunc
            assign w_jmp_ext = w_jmp_off[CAW-1:0];
        end else begin : g_off_sext
            assign w_jmp_ext = {{(CAW-JOW){w_jmp_off[JOW-1]}}, w_jmp_off};
        end
    endgenerate

    // ALU operands and result
    assign w_alu_b = B_sel ? w_imm : r_x;
    assign w_shamt = w_alu_b % L_DW;

    always_comb begin
        w_alu_res = w_alu_b;
        case (ALU_sel)
            4'd0: w_alu_res = r_a + w_alu_b;
            4'd1: w_alu_res = r_a - w_alu_b;
            4'd2: w_alu_res = r_a & w_alu_b;
            4'd3: w_alu_res = r_a | w_alu_b;
            4'd4: w_alu_res = r_a ^ w_alu_b;
            4'd5: w_alu_res = r_a << w_shamt;
            4'd6: w_alu_res = r_a >> w_shamt;
            4'd7: w_alu_res = -r_a;
            default: w_alu_res = w_alu_b;
        endcase
    end

    // A pending result is never overwritten until the consumer has acked it.
    always_comb begin
        w_alu_state_nxt = r_alu_state;
        w_alu_cap       = 1'b0;
        case (r_alu_state)
            S_IDLE: begin
                if (ALU_en) begin
                    w_alu_cap       = 1'b1;
                    w_alu_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (ALU_ack) begin
                    if (ALU_en) w_alu_cap       = 1'b1;
                    else        w_alu_state_nxt = S_IDLE;
                end
            end
            default: w_alu_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_state <= S_IDLE;
            r_alu_out   <= '0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_ge        <= 1'b0;
            r_set       <= 1'b0;
        end else begin
            r_alu_state <= w_alu_state_nxt;
            if (w_alu_cap) begin
                r_alu_out <= w_alu_res;
                r_eq      <= (r_a == w_alu_b);
                r_gt      <= (r_a >  w_alu_b);
                r_ge      <= (r_a >= w_alu_b);
                r_set     <= ((r_a & w_alu_b) != '0);
            end
        end
    end

    assign ALU_vld = (r_alu_state == S_VALID);

    always_comb begin
        case (cond_sel)
            2'd0:    w_flag = r_eq;
            2'd1:    w_flag = r_gt;
            2'd2:    w_flag = r_ge;
            default: w_flag = r_set;
        endcase
    end

    // A branch cannot resolve until a flag set is valid, so the PC waits.
    assign w_stall  = PC_en && (PC_sel == PC_BR) && !ALU_vld;
    assign w_pc_inc = r_pc + L_PC_ONE;
    assign w_pc_jmp = r_pc + w_jmp_ext - jmp_correction;

    always_comb begin
        case (PC_sel)
            PC_INC:  w_pc_nxt = w_pc_inc;
            PC_JMP:  w_pc_nxt = w_pc_jmp;
            PC_BR:   w_pc_nxt = w_flag ? w_pc_jmp : w_pc_inc;
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_x       <= '0;
            r_pc      <= '0;
            r_imm_sel <= '0;
            r_jmp_sel <= '0;
        end else begin
            if (A_en) begin
                case (A_sel)
                    A_IMM:   r_a <= w_imm;
                    A_MEM:   r_a <= w_mem;
                    A_ALU:   r_a <= r_alu_out;
                    A_X:     r_a <= r_x;
                    default: r_a <= r_a;
                endcase
            end
            if (X_en) begin
                case (X_sel)
                    X_IMM:   r_x <= w_imm;
                    X_MEM:   r_x <= w_mem;
                    X_A:     r_x <= r_a;
                    default: r_x <= '0;
                endcase
            end
            if (PC_en && !w_stall) r_pc      <= w_pc_nxt;
            if (imm_sel_en)        r_imm_sel <= utility_addr;
            if (jmp_off_sel_en)    r_jmp_sel <= utility_addr;
        end
    end

    assign branch_stall = w_stall;
    assign ALU_out      = r_alu_out;
    assign eq           = r_eq;
    assign gt           = r_gt;
    assign ge           = r_ge;
    assign set          = r_set;
    assign PC_out       = r_pc;
    assign A_out        = r_a;
    assign X_out        = r_x;

endmodule
